rx_sample_scheduler: RTL and testbench
======================================

RX_SAMPLE_SCHEDULER -- requirements
Module: rx_sample_scheduler

Interface
REQ-001 Parameter DECIM, default 4: raw ADC strobes per decimated sample; legal range 2..16.
REQ-002 Parameter TRIG_DELAY, default 1: clocks from onew_sample_trig to ocorr_trig; legal range 1..4 (covers sample-organizer RAM latency).
REQ-003 Parameter CORR_CYCLES, default 100: clocks the correlator is busy per decimated sample; legal range 1..1023.
REQ-004 crx_clk  input  1  single clock; all logic on its rising edge.
REQ-005 rrx_rst_n  input  1  synchronous, active-low reset.
REQ-006 erx_en  input  1  enable; low forces IDLE.
REQ-007 iadc_strobe  input  1  one-cycle pulse per raw ADC sample.
REQ-008 iclr_err  input  1  one-cycle pulse that clears oerr_overrun.
REQ-009 onew_sample_trig  output  1  one-cycle pulse; band-pass filter and sample organizer accept a decimated sample.
REQ-010 ocorr_trig  output  1  one-cycle pulse; correlator starts a 20-sample-parallel pass.
REQ-011 ocorr_busy  output  1  high while the correlator pass is in progress.
REQ-012 otimestamp  output  32  decimated-sample count, latched at each ocorr_trig.
REQ-013 oerr_overrun  output  1  sticky flag; a decimated sample was dropped.

Function
REQ-014 Decimation counter: counts iadc_strobe from 0 to DECIM-1, then wraps to 0; a strobe arriving at count DECIM-1 is a group-complete event.
REQ-015 Free timestamp counter: increments by 1 on every group-complete event, including dropped ones; wraps from 2^32-1 to 0.
REQ-016 FSM states: IDLE, WAIT, DELAY, CORR.
REQ-017 IDLE -> WAIT when erx_en=1; any state -> IDLE when erx_en=0.
REQ-018 WAIT, group-complete at cycle t: onew_sample_trig=1 in cycle t+1; state -> DELAY.
REQ-019 DELAY lasts TRIG_DELAY clocks; ocorr_trig=1 in cycle t+1+TRIG_DELAY; otimestamp loads the post-increment counter value in the same cycle; state -> CORR.
REQ-020 ocorr_busy=1 from the ocorr_trig cycle for exactly CORR_CYCLES clocks, then state -> WAIT.
REQ-021 Group-complete in DELAY or CORR (overrun): no trigger is issued; oerr_overrun is set next cycle; the timestamp still increments; the FSM is unaffected.
REQ-022 Group-complete in the final CORR cycle counts as overrun; one cycle later in WAIT it is accepted.
REQ-023 iclr_err clears oerr_overrun next cycle; if iclr_err and an overrun occur in the same cycle, set wins.
REQ-024 erx_en=0: decimation counter to 0; onew_sample_trig, ocorr_trig and ocorr_busy to 0 next cycle; timestamp, otimestamp and oerr_overrun hold.
REQ-025 All outputs are registered; no combinational input-to-output path.

Reset
REQ-026 rrx_rst_n=0 at a rising edge sets: state IDLE, both counters 0, otimestamp 0, oerr_overrun 0, all pulses and ocorr_busy 0.
REQ-027 Reset mid-pass aborts it; no trigger is issued until a full new group completes after reset release.

Configuration
REQ-028 Macro RX_SCHED_OVERRUN_CNT_EN defined: adds output oovr_count (16 bits), saturating at 0xFFFF, incremented on every overrun, cleared by reset and by iclr_err (increment wins on coincidence).
REQ-029 Macro RX_SCHED_OVERRUN_CNT_EN undefined: port and logic absent; all other behaviour identical.

Structure
REQ-030 Shared package rx_pkg holds the FSM state encoding, default DECIM, TRIG_DELAY and CORR_CYCLES values, and the 32-bit timestamp width constant.
REQ-031 One sub-module, rx_decim_counter, contains the decimation counter and the group-complete pulse; the FSM, timers and timestamp stay in the top.

Verification
REQ-032 Defaults, strobe every 128 clocks, 8 groups -> 8 onew_sample_trig pulses spaced 512 clocks apart; each ocorr_trig 1 clock later; otimestamp 1..8; ocorr_busy 100 clocks wide; no overrun.
REQ-033 CORR_CYCLES=100, strobe every 10 clocks -> the second group completes while busy; oerr_overrun=1, oovr_count=1, no trigger issued, timestamp still increments to 2.
REQ-034 Overrun set, then iclr_err pulsed in the same cycle as a new overrun -> oerr_overrun stays 1; a lone iclr_err later -> 0 next cycle.
REQ-035 Timestamp preloaded to 0xFFFFFFFF via force -> next accepted ocorr_trig shows otimestamp=0.
REQ-036 rrx_rst_n low for 1 clock mid-CORR -> ocorr_busy 0 next cycle; the next trigger appears only after 4 fresh strobes.
REQ-037 erx_en dropped after 2 strobes, then re-raised -> decimation restarts; 4 further strobes needed before onew_sample_trig.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg -- shared definitions for the RX sample scheduler.
// Holds the scheduler FSM state encoding, the default values of the
// DECIM / TRIG_DELAY / CORR_CYCLES parameters and the timestamp width.
package rx_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DELAY = 2'd2,
    ST_CORR  = 2'd3
  } rx_state_e;

  localparam int DEF_DECIM       = 4;
  localparam int DEF_TRIG_DELAY  = 1;
  localparam int DEF_CORR_CYCLES = 100;
  localparam int TS_W            = 32;

  // Width of the shared DELAY/CORR phase timer (CORR_CYCLES up to 1023)
  localparam int TMR_W           = 10;

endpackage

// File: rtl/rx_decim_counter.sv
// rx_decim_counter -- counts raw ADC strobes modulo DECIM and flags the
// strobe that completes a decimation group.
// Ports:
//   crx_clk      clock
//   rrx_rst_n    synchronous active-low reset
//   erx_en       enable; low holds the count at 0
//   iadc_strobe  one-cycle pulse per raw ADC sample
//   group_done   same-cycle pulse: strobe arrived at count DECIM-1
import rx_pkg::*;

module rx_decim_counter #(
  parameter int DECIM = DEF_DECIM
) (
  input  logic crx_clk,
  input  logic rrx_rst_n,
  input  logic erx_en,
  input  logic iadc_strobe,
  output logic group_done
);

  localparam int            CW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt_r;
  logic          last_s;

  assign last_s     = (cnt_r == LAST);
  // Internal to the block: the top registers everything it drives out.
  assign group_done = erx_en & iadc_strobe & last_s;

  // Decimation count register, wraps at DECIM-1
  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (!erx_en) begin
      cnt_r <= {CW{1'b0}};
    end else if (iadc_strobe) begin
      if (last_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rx_sample_scheduler.sv
// rx_sample_scheduler -- schedules decimated-sample triggers for the
// band-pass filter / sample organizer and the correlator.
// Ports:
//   crx_clk           clock (rising edge)
//   rrx_rst_n         synchronous active-low reset
//   erx_en            enable; low forces IDLE
//   iadc_strobe       one pulse per raw ADC sample
//   iclr_err          pulse clearing oerr_overrun
//   onew_sample_trig  pulse: a decimated sample is accepted
//   ocorr_trig        pulse: correlator pass starts
//   ocorr_busy        high for CORR_CYCLES clocks from ocorr_trig
//   otimestamp        decimated-sample count latched at ocorr_trig
//   oerr_overrun      sticky: a decimated sample was dropped
//   oovr_count        (only with RX_SCHED_OVERRUN_CNT_EN) saturating
//                     16-bit overrun counter
// Optional feature macro: RX_SCHED_OVERRUN_CNT_EN
import rx_pkg::*;

module rx_sample_scheduler #(
  parameter int DECIM       = DEF_DECIM,
  parameter int TRIG_DELAY  = DEF_TRIG_DELAY,
  parameter int CORR_CYCLES = DEF_CORR_CYCLES
) (
  input  logic            crx_clk,
  input  logic            rrx_rst_n,
  input  logic            erx_en,
  input  logic            iadc_strobe,
  input  logic            iclr_err,
  output logic            onew_sample_trig,
  output logic            ocorr_trig,
  output logic            ocorr_busy,
  output logic [TS_W-1:0] otimestamp,
  output logic            oerr_overrun
`ifdef RX_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]     oovr_count
`endif
);

  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(TRIG_DELAY - 1);
  localparam logic [TMR_W-1:0] CORR_LAST = TMR_W'(CORR_CYCLES - 1);

  rx_state_e         state_r, next_state_s;
  logic [TMR_W-1:0]  tmr_r;
  logic [TS_W-1:0]   ts_r;
  logic              group_done_s;
  logic              trig_issue_s;
  logic              corr_start_s;
  logic              ovr_s;

  logic              new_trig_r;
  logic              corr_trig_r;
  logic              corr_busy_r;
  logic [TS_W-1:0]   otimestamp_r;
  logic              err_r;

  rx_decim_counter #(
    .DECIM (DECIM)
  ) u_decim (
    .crx_clk     (crx_clk),
    .rrx_rst_n   (rrx_rst_n),
    .erx_en      (erx_en),
    .iadc_strobe (iadc_strobe),
    .group_done  (group_done_s)
  );

  // Next-state and trigger/overrun decode
  always_comb begin
    next_state_s = state_r;
    trig_issue_s = 1'b0;
    corr_start_s = 1'b0;
    ovr_s        = 1'b0;
    if (!erx_en) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (group_done_s) begin
            next_state_s = ST_DELAY;
            trig_issue_s = 1'b1;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        ST_DELAY: begin
          ovr_s = group_done_s;
          if (tmr_r == DLY_LAST) begin
            next_state_s = ST_CORR;
            corr_start_s = 1'b1;
          end else begin
            next_state_s = ST_DELAY;
          end
        end
        ST_CORR: begin
          // Includes the final CORR cycle: a group there is still dropped.
          ovr_s = group_done_s;
          if (tmr_r == CORR_LAST) begin
            next_state_s = ST_WAIT;
          end else begin
            next_state_s = ST_CORR;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and phase timer (restarts on every state change)
  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      state_r <= ST_IDLE;
      tmr_r   <= {TMR_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        tmr_r <= {TMR_W{1'b0}};
      end else begin
        tmr_r <= tmr_r + TMR_W'(1);
      end
    end
  end

  // Free-running timestamp: counts every completed group, dropped or not
  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      ts_r <= {TS_W{1'b0}};
    end else if (group_done_s) begin
      ts_r <= ts_r + TS_W'(1);
    end else begin
      ts_r <= ts_r;
    end
  end

  // Registered trigger, busy and timestamp outputs
  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      new_trig_r   <= 1'b0;
      corr_trig_r  <= 1'b0;
      corr_busy_r  <= 1'b0;
      otimestamp_r <= {TS_W{1'b0}};
    end else begin
      new_trig_r  <= trig_issue_s;
      corr_trig_r <= corr_start_s;
      corr_busy_r <= (next_state_s == ST_CORR);
      // ts_r already includes the accepted group's increment here.
      if (corr_start_s) begin
        otimestamp_r <= ts_r;
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a coincident clear
  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      err_r <= 1'b0;
    end else if (ovr_s) begin
      err_r <= 1'b1;
    end else if (iclr_err) begin
      err_r <= 1'b0;
    end
  end

  assign onew_sample_trig = new_trig_r;
  assign ocorr_trig       = corr_trig_r;
  assign ocorr_busy       = corr_busy_r;
  assign otimestamp       = otimestamp_r;
  assign oerr_overrun     = err_r;

`ifdef RX_SCHED_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_r;

  // Saturating overrun counter; increment beats a coincident clear
  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      ovr_cnt_r <= 16'd0;
    end else if (ovr_s) begin
      if (ovr_cnt_r != 16'hFFFF) begin
        ovr_cnt_r <= ovr_cnt_r + 16'd1;
      end
    end else if (iclr_err) begin
      ovr_cnt_r <= 16'd0;
    end
  end

  assign oovr_count = ovr_cnt_r;
`endif

endmodule

// File: tb/tb_rx_sample_scheduler.sv
// Testbench for rx_sample_scheduler (default parameters). A cycle-level
// reference model predicts trigger cycles, timestamps, busy and overrun;
// expected trigger events go into queues consumed by a negedge monitor.
module tb_rx_sample_scheduler;

  localparam int  DECIM = 4;
  localparam int  TD    = 1;
  localparam int  CC    = 100;

  logic        crx_clk = 1'b0;
  logic        rrx_rst_n = 1'b0;
  logic        erx_en = 1'b0;
  logic        iadc_strobe = 1'b0;
  logic        iclr_err = 1'b0;
  logic        onew_sample_trig;
  logic        ocorr_trig;
  logic        ocorr_busy;
  logic [31:0] otimestamp;
  logic        oerr_overrun;
`ifdef RX_SCHED_OVERRUN_CNT_EN
  logic [15:0] oovr_count;
`endif

  rx_sample_scheduler #(
    .DECIM       (DECIM),
    .TRIG_DELAY  (TD),
    .CORR_CYCLES (CC)
  ) dut (
    .crx_clk          (crx_clk),
    .rrx_rst_n        (rrx_rst_n),
    .erx_en           (erx_en),
    .iadc_strobe      (iadc_strobe),
    .iclr_err         (iclr_err),
    .onew_sample_trig (onew_sample_trig),
    .ocorr_trig       (ocorr_trig),
    .ocorr_busy       (ocorr_busy),
    .otimestamp       (otimestamp),
    .oerr_overrun     (oerr_overrun)
`ifdef RX_SCHED_OVERRUN_CNT_EN
    ,
    .oovr_count       (oovr_count)
`endif
  );

  always #5 crx_clk = ~crx_clk;

  typedef struct {
    longint      cyc;
    logic [31:0] ts;
  } ev_t;

  ev_t    nq[$];
  ev_t    cq[$];

  int     total = 0;
  int     bad = 0;

  // Reference model state
  longint      cyc = 0;
  int          m_dcnt = 0;
  logic [31:0] m_ts = 32'd0;
  logic        m_err = 1'b0;
  int          m_ovr_cnt = 0;
  logic        m_busy = 1'b0;
  logic        in_idle = 1'b1;
  longint      pass_start = -1;
  longint      pass_end = -1;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One model step per rising edge, using the inputs of the ending cycle.
  // A gc at cycle t is accepted if no pass window (t, t+TD+CC] is open.
  task automatic model_step();
    longint cur;
    bit     gc;
    bit     ovr;
    cur = cyc;
    cyc++;
    gc  = 1'b0;
    ovr = 1'b0;
    if (!rrx_rst_n) begin
      m_dcnt = 0; m_ts = 32'd0; m_err = 1'b0; m_ovr_cnt = 0;
      pass_start = -1; pass_end = -1; in_idle = 1'b1;
      nq.delete(); cq.delete();
    end else if (!erx_en) begin
      m_dcnt = 0; pass_start = -1; pass_end = -1; in_idle = 1'b1;
      nq.delete(); cq.delete();
      if (iclr_err) begin
        m_err = 1'b0; m_ovr_cnt = 0;
      end
    end else begin
      if (iadc_strobe) begin
        if (m_dcnt == DECIM - 1) begin
          gc = 1'b1; m_dcnt = 0;
        end else begin
          m_dcnt++;
        end
      end
      if (gc) begin
        m_ts = m_ts + 32'd1;
        if (!in_idle) begin
          if (cur <= pass_end) begin
            ovr = 1'b1;
          end else begin
            pass_start = cur + 1 + TD;
            pass_end   = cur + TD + CC;
            nq.push_back('{cyc: cur + 1, ts: 32'd0});
            cq.push_back('{cyc: cur + 1 + TD, ts: m_ts});
          end
        end
      end
      in_idle = 1'b0;
      if (ovr) begin
        m_err = 1'b1;
        if (m_ovr_cnt < 65535) m_ovr_cnt++;
      end else if (iclr_err) begin
        m_err = 1'b0; m_ovr_cnt = 0;
      end
    end
    m_busy = (cyc >= pass_start) && (cyc <= pass_end);
  endtask

  initial begin
    forever begin
      @(posedge crx_clk);
      model_step();
    end
  end

  // Monitor: compare level outputs every cycle, pop trigger events on match
  initial begin
    forever begin
      @(negedge crx_clk);
      check("busy", ocorr_busy, m_busy);
      check("overrun", oerr_overrun, m_err);
`ifdef RX_SCHED_OVERRUN_CNT_EN
      check("ovr_count", oovr_count, m_ovr_cnt);
`endif
      if (nq.size() > 0 && nq[0].cyc == cyc) begin
        check("new_trig", onew_sample_trig, 1);
        void'(nq.pop_front());
      end else if (onew_sample_trig) begin
        check("new_trig_spurious", 1, 0);
      end
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        check("corr_trig", ocorr_trig, 1);
        check("timestamp", otimestamp, cq[0].ts);
        void'(cq.pop_front());
      end else if (ocorr_trig) begin
        check("corr_trig_spurious", 1, 0);
      end
    end
  end

  // Drive one cycle of inputs (called right after a falling edge)
  task automatic drive(input logic s, input logic c);
    iadc_strobe = s;
    iclr_err    = c;
    @(negedge crx_clk);
    iadc_strobe = 1'b0;
    iclr_err    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0);
      idle(gap - 1);
    end
  endtask

  initial begin
    bit found;
    @(negedge crx_clk);
    idle(3);
    rrx_rst_n = 1'b1;
    idle(1);
    check("reset_timestamp", otimestamp, 0);
    check("reset_new_trig", onew_sample_trig, 0);
    erx_en = 1'b1;
    idle(4);

    // Nominal cadence: 8 groups, no overrun
    strobes(32, 128);
    idle(50);

    // Fast strobes: second group lands inside the correlator pass
    strobes(8, 10);
    idle(200);

    // Overrun coincident with a clear: set must win
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_dcnt == DECIM - 1 && pass_end >= cyc && pass_start >= 0) begin
        drive(1'b1, 1'b1);
        found = 1'b1;
      end else begin
        drive((i % 7) == 0, 1'b0);
      end
    end
    check("coincident_clear_found", found, 1);
    idle(200);
    drive(1'b0, 1'b1);
    idle(3);

    // Timestamp wrap
    force dut.ts_r = 32'hFFFFFFFF;
    m_ts = 32'hFFFFFFFF;
    idle(1);
    release dut.ts_r;
    idle(2);
    strobes(4, 3);
    idle(200);

    // Reset mid-CORR aborts the pass
    strobes(4, 3);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_busy && cyc > pass_start + 10) found = 1'b1;
      else idle(1);
    end
    check("reached_corr", found, 1);
    rrx_rst_n = 1'b0;
    idle(1);
    rrx_rst_n = 1'b1;
    strobes(3, 5);
    idle(20);
    strobes(1, 5);
    idle(200);

    // Enable drop restarts decimation
    strobes(2, 5);
    erx_en = 1'b0;
    idle(3);
    erx_en = 1'b1;
    strobes(3, 5);
    idle(10);
    strobes(1, 5);
    idle(200);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      erx_en = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
    end
    erx_en = 1'b1;
    idle(250);
    check("pending_new_trig", nq.size(), 0);
    check("pending_corr_trig", cq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
